// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared types and constants for the T-cell step counter
//
// Purpose: controller state encoding and count-direction constants used by
//          tff_count_ctrl and its testbench.
// Ports:   none (package).
package tff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/tff_hold_cell.sv
// rtl/tff_hold_cell.sv - one synchronous T flip-flop cell with hold, preset and clear
//
// Purpose: single storage bit of the bank. Synchronous controls, priority
//          preset/clear > hold > toggle.
// Ports:
//   CLK       in   clock, rising edge
//   nCLEAR    in   asynchronous active-low reset (q -> 0)
//   t         in   toggle enable
//   nHOLD     in   active-low hold; keeps q regardless of t
//   nPRESET   in   active-low synchronous preset (q -> 1)
//   nCLEAR_s  in   active-low synchronous clear (q -> 0)
//   q         out  cell state
module tff_hold_cell (
  input  logic CLK,
  input  logic nCLEAR,
  input  logic t,
  input  logic nHOLD,
  input  logic nPRESET,
  input  logic nCLEAR_s,
  output logic q
);

  // Preset is checked before clear; the controller never asserts both.
  always_ff @(posedge CLK or negedge nCLEAR) begin
    if (!nCLEAR) begin
      q <= 1'b0;
    end else if (!nPRESET) begin
      q <= 1'b1;
    end else if (!nCLEAR_s) begin
      q <= 1'b0;
    end else if (!nHOLD) begin
      q <= q;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - loadable up/down step counter built from a bank of T cells
//
// Purpose: FSM (IDLE/LOAD/RUN/DONE) that drives per-bit toggle mask, hold and
//          preset/clear lines of WIDTH tff_hold_cell instances.
// Optional: define TFF_COUNT_CTRL_SATURATE_EN to stop the bank at the terminal
//           count instead of wrapping.
// Ports:
//   CLK       in   clock, rising edge
//   nCLEAR    in   asynchronous active-low reset
//   start     in   begin a counting run (IDLE only)
//   load      in   parallel load request (IDLE only, beats start)
//   load_val  in   [WIDTH]  value placed in the bank by a load
//   dir       in   1 = up, 0 = down (latched on start)
//   steps     in   [STEP_W] number of steps in the run (latched on start)
//   hold_req  in   freeze the bank this cycle while in RUN
//   Q         out  [WIDTH]  bank state
//   busy      out  high in LOAD, RUN, DONE
//   done      out  one-cycle pulse in DONE
//   tc        out  terminal count for the latched direction
module tff_count_ctrl
  import tff_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              CLK,
  input  logic              nCLEAR,
  input  logic              start,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic [STEP_W-1:0] steps,
  input  logic              hold_req,
  output logic [WIDTH-1:0]  Q,
  output logic              busy,
  output logic              done,
  output logic              tc
);

  state_t             state, state_nxt;
  logic               dir_q;
  logic [STEP_W-1:0]  remaining;
  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   t;
  logic [WIDTH-1:0]   npreset;
  logic [WIDTH-1:0]   nclear_s;
  logic               nhold;
  logic               run_step;
  logic               accept;

  assign accept   = (state == IDLE) && !load && start;
  assign run_step = (state == RUN) && !hold_req;

  always_ff @(posedge CLK or negedge nCLEAR) begin
    if (!nCLEAR) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load)       state_nxt = LOAD;
        else if (start) state_nxt = (steps == '0) ? DONE : RUN;
      end
      LOAD: state_nxt = IDLE;
      RUN:  if (run_step && remaining == STEP_W'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    nhold    = !((state == RUN) && hold_req);
    npreset  = '1;
    nclear_s = '1;
    if (state == LOAD) begin
      npreset  = ~load_val;
      nclear_s = load_val;
    end
  end

  always_ff @(posedge CLK or negedge nCLEAR) begin
    if (!nCLEAR) begin
      dir_q     <= DIR_UP;
      remaining <= '0;
    end else if (accept) begin
      dir_q     <= dir;
      remaining <= steps;
    end else if (run_step) begin
      remaining <= remaining - STEP_W'(1);
    end
  end

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic up_all, dn_all;
    mask   = '0;
    up_all = 1'b1;
    dn_all = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (dir_q == DIR_UP) ? up_all : dn_all;
      up_all  = up_all & Q[i];
      dn_all  = dn_all & ~Q[i];
    end
  end

  assign tc = (dir_q == DIR_UP) ? (&Q) : ~(|Q);

`ifdef TFF_COUNT_CTRL_SATURATE_EN
  assign t = (run_step && !tc) ? mask : '0;
`else
  assign t = run_step ? mask : '0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_hold_cell u_cell (
      .CLK      (CLK),
      .nCLEAR   (nCLEAR),
      .t        (t[i]),
      .nHOLD    (nhold),
      .nPRESET  (npreset[i]),
      .nCLEAR_s (nclear_s[i]),
      .q        (Q[i])
    );
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - directed self-checking bench for tff_count_ctrl
module tb_tff_count_ctrl;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 8;

`ifdef TFF_COUNT_CTRL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              nCLEAR;
  logic              start;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              dir;
  logic [STEP_W-1:0] steps;
  logic              hold_req;
  logic [WIDTH-1:0]  Q;
  logic              busy;
  logic              done;
  logic              tc;

  int checks = 0;
  int errors = 0;

  tff_count_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .CLK      (CLK),
    .nCLEAR   (nCLEAR),
    .start    (start),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .steps    (steps),
    .hold_req (hold_req),
    .Q        (Q),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Check Q, busy, done together after the current edge.
  task automatic chk3(input string tag, input int q, input int b, input int d);
    check({tag, ".Q"}, int'(Q), q);
    check({tag, ".busy"}, int'(busy), b);
    check({tag, ".done"}, int'(done), d);
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
    check("load.busy_load_state", int'(busy), 1);
    step();
    chk3("load.after", int'(v), 0, 0);
  endtask

  initial begin
    nCLEAR = 1'b0; start = 1'b0; load = 1'b0; load_val = '0;
    dir = 1'b1; steps = '0; hold_req = 1'b0;
    #12;
    chk3("reset", 0, 0, 0);
    check("reset.tc", int'(tc), 0);
    step();
    nCLEAR = 1'b1;

    // Reset mid-run
    start = 1'b1; dir = 1'b1; steps = 8'd5;
    step(); start = 1'b0;
    chk3("rmr.accept", 0, 1, 0);
    step(); check("rmr.s1", int'(Q), 1);
    step(); check("rmr.s2", int'(Q), 2);
    nCLEAR = 1'b0;
    #1;
    chk3("rmr.async", 0, 0, 0);
    #1 nCLEAR = 1'b1;
    step();
    start = 1'b1; steps = 8'd3;
    step(); start = 1'b0;
    chk3("run3.c1", 0, 1, 0);
    step(); chk3("run3.c2", 1, 1, 0);
    step(); chk3("run3.c3", 2, 1, 0);
    step(); chk3("run3.c4", 3, 1, 1);
    step(); chk3("run3.end", 3, 0, 0);

    // Load then count down; start/load pulsed mid-run are ignored
    do_load(4'b1010);
    start = 1'b1; dir = 1'b0; steps = 8'd3;
    step(); start = 1'b0; dir = 1'b1; steps = 8'd9;
    chk3("dn.c1", 10, 1, 0);
    step(); chk3("dn.c2", 9, 1, 0);
    start = 1'b1; load = 1'b1; load_val = 4'h0;
    step(); chk3("dn.c3", 8, 1, 0);
    start = 1'b0; load = 1'b0;
    step(); chk3("dn.c4", 7, 1, 1);
    check("dn.tc", int'(tc), 0);
    step(); chk3("dn.end", 7, 0, 0);

    // Wrap / saturate going up from E
    do_load(4'hE);
    start = 1'b1; dir = 1'b1; steps = 8'd3;
    step(); start = 1'b0;
    check("wrap.c1.Q", int'(Q), 14);
    check("wrap.c1.tc", int'(tc), 0);
    step();
    check("wrap.c2.Q", int'(Q), 15);
    check("wrap.c2.tc", int'(tc), 1);
    step(); chk3("wrap.c3", SAT ? 15 : 0, 1, 0);
    step(); chk3("wrap.c4", SAT ? 15 : 1, 1, 1);
    step(); chk3("wrap.end", SAT ? 15 : 1, 0, 0);

    // Hold for two cycles
    do_load(4'h0);
    start = 1'b1; dir = 1'b1; steps = 8'd4;
    step(); start = 1'b0;
    chk3("hold.c0", 0, 1, 0);
    step(); chk3("hold.c1", 1, 1, 0);
    hold_req = 1'b1;
    step(); chk3("hold.c2", 1, 1, 0);
    step(); chk3("hold.c3", 1, 1, 0);
    hold_req = 1'b0;
    step(); chk3("hold.c4", 2, 1, 0);
    step(); chk3("hold.c5", 3, 1, 0);
    step(); chk3("hold.c6", 4, 1, 1);
    step(); chk3("hold.end", 4, 0, 0);

    // load beats start; start dropped
    load = 1'b1; load_val = 4'h5; start = 1'b1; dir = 1'b1; steps = 8'd2;
    step(); load = 1'b0; start = 1'b0;
    chk3("prio.load", 4, 1, 0);
    step(); chk3("prio.after", 5, 0, 0);
    step(); chk3("prio.norun", 5, 0, 0);

    // steps = 0 goes straight to DONE
    start = 1'b1; steps = 8'd0;
    step(); start = 1'b0;
    chk3("zero.done", 5, 1, 1);
    step(); chk3("zero.end", 5, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
